component_topn_sweep: RTL and testbench
=======================================

# component_topn_sweep

Parametrised successor to the day-08 root sweep stage. After union-find completes, it walks node indices `0..node_count-1` through a fixed-latency query port into the union-find. It ranks roots by component size into a sorted top-N list, selectable as largest-first or smallest-first. Results are held on a valid/ready output together with the root count, the product of ranked sizes and a sticky protocol-error flag.

## Interface
Parameters:
- `MAX_NODE_COUNT`, default 2000: upper bound on nodes.
- `INDEX_BIT_WIDTH`, localparam `$clog2(MAX_NODE_COUNT)`: width of a node index.
- `SIZE_BIT_WIDTH`, localparam `$clog2(MAX_NODE_COUNT+1)`: width of a component size or a count.
- `TOP_N`, default 3: ranked slots, 1..16.
- `QUERY_LATENCY`, default 1: cycles from query handshake to `resp_valid`, 1..8.
- `PRODUCT_BIT_WIDTH`, localparam `SIZE_BIT_WIDTH*TOP_N`: width of `top_product`.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request; accepted only in IDLE.
- `node_count` in SIZE_BIT_WIDTH: sampled at start; values above MAX_NODE_COUNT clamp to MAX_NODE_COUNT.
- `mode_smallest` in 1: sampled at start; 0 ranks largest-first, 1 ranks smallest-first.
- `busy` out 1: high in any state other than IDLE.
- `query_valid` out 1, `query_ready` in 1, `query_index` out INDEX_BIT_WIDTH: union-find lookup handshake.
- `resp_valid` in 1, `resp_is_root` in 1, `resp_size` in SIZE_BIT_WIDTH: in-order responses.
- `out_valid` out 1, `out_ready` in 1: result handshake.
- `top_sizes[0:TOP_N-1]` out SIZE_BIT_WIDTH: ranked sizes.
- `top_roots[0:TOP_N-1]` out INDEX_BIT_WIDTH: matching root indices.
- `top_count` out `$clog2(TOP_N+1)`: number of filled slots.
- `root_count` out SIZE_BIT_WIDTH: roots seen with nonzero size.
- `top_product` out PRODUCT_BIT_WIDTH: product of filled slot sizes.
- `resp_error` out 1: sticky protocol-error flag.

## Operation
- States and transitions:
  - IDLE → ISSUE on `start`. At that edge, clear slots, counts and `resp_error`, and latch the mode and clamped count.
  - IDLE → HOLD when the latched count is 0.
  - ISSUE: `query_valid`=1 and `query_index`=sweep counter; the counter increments on each handshake. The handshake on index `count-1` moves to DRAIN.
  - DRAIN: wait until the in-flight pipeline is empty, then go to HOLD.
  - HOLD: `out_valid`=1 with all result outputs stable. On `out_ready` go to IDLE with `out_valid`=0; results stay readable.
- Tag pipeline: a QUERY_LATENCY-deep shift register carries {valid, index} for each accepted query. A response is consumed when the tag at the pipeline tail is valid.
- Protocol errors: `resp_valid` differing from the tail valid bit sets `resp_error`. Such a response is ignored, and a missing response counts as non-root.
- Ranking:
  - A consumed response with `resp_is_root`=1 and `resp_size`≠0 increments `root_count`.
  - Largest mode inserts it at the first slot d that is empty or has `resp_size` > `top_sizes[d]`.
  - Smallest mode inserts it at the first slot that is empty or has `resp_size` < `top_sizes[d]`.
  - Entries below the insertion point shift down one slot; the last entry is dropped.
  - Ties never displace an existing entry, so the lower index ranks first.
- Empty slots hold size 0 and root 0.
- `top_product` is the product of filled slots only, 0 when `top_count`=0. It is combinational from the slot registers, with no overflow because of its width.
- `start` outside IDLE is ignored, including in HOLD.

## Timing
- Reset, with `rst_n` low at an edge:
  - State returns to IDLE.
  - `query_valid`, `busy`, `out_valid` and `resp_error` are 0.
  - All slots, `top_count`, `root_count` and the tag pipeline are 0.
  - Reset mid-sweep abandons the sweep, and any later `resp_valid` is ignored until the next start.
- With `query_ready` held high and `start` accepted at edge 0:
  - Index k handshakes in cycle 1+k.
  - Its response arrives in cycle 1+k+QUERY_LATENCY, and the slots update at the end of that cycle.
  - `out_valid` rises in cycle `node_count+QUERY_LATENCY+1`.
- Throughput is one query per cycle; backpressure on `query_ready` only stretches ISSUE.
- A response and a new issue in the same cycle are both processed.

## Structure
- Package `component_pkg` holds the state enum (IDLE, ISSUE, DRAIN, HOLD), the `size_t`/`index_t` typedefs and the tag struct {valid, index}.
- Sub-module `topn_insert` is combinational. It takes the slot arrays, candidate size/index and mode, and returns the next slot arrays and `top_count`. The top level owns the FSM, tag pipeline and registers.

## Test plan
- N=6, TOP_N=3, largest mode, root sizes {idx0:3, idx2:1, idx4:2}, others non-root → top_sizes {3,2,1}, roots {0,4,2}, root_count 3, product 6.
- Same stimulus with `mode_smallest`=1 → sizes {1,2,3}, roots {2,4,0}; then two roots only → top_count 2, slot 2 = 0, product over 2 entries.
- Tie: idx1 size 4, idx5 size 4, idx3 size 5 → roots {3,1,5}.
- `query_ready` toggling 1,0,0,1…, QUERY_LATENCY=3 → every index 0..N-1 queried exactly once, results identical to the ungated run.
- Spurious `resp_valid` while in IDLE, and a response withheld in ISSUE → `resp_error`=1 at `out_valid`; the next start clears it.
- `node_count`=0 → `out_valid` at cycle 1 with top_count 0, product 0. `rst_n` low mid-ISSUE → IDLE, all outputs 0, late responses ignored.

Source files
------------

// File: rtl/component_pkg.sv
// Shared types for the component top-N sweep stage: FSM states, container
// typedefs for sizes and node indices, the query tag layout, and the ranking
// comparison used by the insertion network.
package component_pkg;

   // Widest size/index any instance is expected to carry; per-instance ports are
   // narrower and are widened into these containers only for comparison.
   localparam int CONTAINER_BIT_WIDTH = 16;

   typedef logic [CONTAINER_BIT_WIDTH-1:0] size_t;
   typedef logic [CONTAINER_BIT_WIDTH-1:0] index_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      HOLD
   } state_t;

   // One entry of the in-flight query pipeline.
   typedef struct packed {
      logic   valid;
      index_t index;
   } tag_t;

   // True when a candidate must be placed ahead of an occupied slot. Equal
   // sizes never rank ahead, so earlier (lower-index) roots keep their place.
   function automatic logic ranks_before(input logic smallest, input size_t cand,
                                         input size_t held);
      return smallest ? (cand < held) : (cand > held);
   endfunction

endpackage

// File: rtl/topn_insert.sv
// Combinational insertion of one candidate root into a sorted top-N list.
// Finds the first slot that is empty or ranks behind the candidate, writes the
// candidate there and shifts the tail down by one, dropping the last entry.
module topn_insert
   import component_pkg::*;
#(
   parameter int TOP_N           = 3,
   parameter int SIZE_BIT_WIDTH  = 11,
   parameter int INDEX_BIT_WIDTH = 11,
   parameter int COUNT_BIT_WIDTH = 2
) (
   input  logic [SIZE_BIT_WIDTH-1:0]  sizes      [0:TOP_N-1],
   input  logic [INDEX_BIT_WIDTH-1:0] roots      [0:TOP_N-1],
   input  logic [COUNT_BIT_WIDTH-1:0] count,
   input  logic [SIZE_BIT_WIDTH-1:0]  cand_size,
   input  logic [INDEX_BIT_WIDTH-1:0] cand_root,
   input  logic                       mode_smallest,
   output logic [SIZE_BIT_WIDTH-1:0]  next_sizes [0:TOP_N-1],
   output logic [INDEX_BIT_WIDTH-1:0] next_roots [0:TOP_N-1],
   output logic [COUNT_BIT_WIDTH-1:0] next_count
);

   int   pos;
   logic found;

   // Locate the insertion slot: first empty slot or first slot the candidate beats.
   always_comb begin
      // NOTE: every always_comb output gets a default before any branch, otherwise
      // paths that skip an assignment infer a latch.
      pos   = TOP_N;
      found = 1'b0;
      for (int d = 0; d < TOP_N; d++) begin
         if (!found && ((d >= int'(count)) ||
                        ranks_before(mode_smallest, size_t'(cand_size), size_t'(sizes[d])))) begin
            pos   = d;
            found = 1'b1;
         end
      end
   end

   // Build the shifted list and the new fill count.
   always_comb begin
      next_sizes[0] = (found && pos == 0) ? cand_size : sizes[0];
      next_roots[0] = (found && pos == 0) ? cand_root : roots[0];
      for (int d = 1; d < TOP_N; d++) begin
         if (found && d == pos) begin
            next_sizes[d] = cand_size;
            next_roots[d] = cand_root;
         end else if (found && d > pos) begin
            next_sizes[d] = sizes[d-1];
            next_roots[d] = roots[d-1];
         end else begin
            next_sizes[d] = sizes[d];
            next_roots[d] = roots[d];
         end
      end
      next_count = count;
      if (found && (count != COUNT_BIT_WIDTH'(TOP_N))) begin
         next_count = count + COUNT_BIT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/component_topn_sweep.sv
// Post-union-find sweep: queries every node index through a fixed-latency
// lookup port, ranks component roots by size into a top-N list (largest- or
// smallest-first), and holds the result on a valid/ready output together with
// the root count, the product of ranked sizes and a sticky protocol-error flag.
module component_topn_sweep
   import component_pkg::*;
#(
   parameter int  MAX_NODE_COUNT    = 2000,
   parameter int  TOP_N             = 3,
   parameter int  QUERY_LATENCY     = 1,
   localparam int INDEX_BIT_WIDTH   = $clog2(MAX_NODE_COUNT),
   localparam int SIZE_BIT_WIDTH    = $clog2(MAX_NODE_COUNT + 1),
   localparam int COUNT_BIT_WIDTH   = $clog2(TOP_N + 1),
   localparam int PRODUCT_BIT_WIDTH = SIZE_BIT_WIDTH * TOP_N
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [SIZE_BIT_WIDTH-1:0]    node_count,
   input  logic                         mode_smallest,
   output logic                         busy,
   output logic                         query_valid,
   input  logic                         query_ready,
   output logic [INDEX_BIT_WIDTH-1:0]   query_index,
   input  logic                         resp_valid,
   input  logic                         resp_is_root,
   input  logic [SIZE_BIT_WIDTH-1:0]    resp_size,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [SIZE_BIT_WIDTH-1:0]    top_sizes [0:TOP_N-1],
   output logic [INDEX_BIT_WIDTH-1:0]   top_roots [0:TOP_N-1],
   output logic [COUNT_BIT_WIDTH-1:0]   top_count,
   output logic [SIZE_BIT_WIDTH-1:0]    root_count,
   output logic [PRODUCT_BIT_WIDTH-1:0] top_product,
   output logic                         resp_error
);

   // Exact-width tag for this instance's index range.
   typedef struct packed {
      logic                       valid;
      logic [INDEX_BIT_WIDTH-1:0] index;
   } sweep_tag_t;

   state_t                     state;
   logic [SIZE_BIT_WIDTH-1:0]  count_q;
   logic                       mode_q;
   logic                       armed;
   logic [INDEX_BIT_WIDTH-1:0] sweep_idx;
   sweep_tag_t                 tag_pipe [0:QUERY_LATENCY-1];
   sweep_tag_t                 in_tag;
   sweep_tag_t                 tail;

   logic [SIZE_BIT_WIDTH-1:0]  clamped_count;
   logic                       start_accept;
   logic                       issue_fire;
   logic                       last_issue;
   logic                       upstream_busy;
   logic                       rank_en;
   logic                       proto_err;

   logic [SIZE_BIT_WIDTH-1:0]  next_sizes [0:TOP_N-1];
   logic [INDEX_BIT_WIDTH-1:0] next_roots [0:TOP_N-1];
   logic [COUNT_BIT_WIDTH-1:0] next_count;

   assign clamped_count = (node_count > SIZE_BIT_WIDTH'(MAX_NODE_COUNT))
                          ? SIZE_BIT_WIDTH'(MAX_NODE_COUNT) : node_count;
   assign start_accept  = (state == IDLE) && start;
   assign issue_fire    = (state == ISSUE) && query_ready;
   assign last_issue    = (SIZE_BIT_WIDTH'(sweep_idx) == (count_q - SIZE_BIT_WIDTH'(1)));

   assign in_tag.valid  = issue_fire;
   assign in_tag.index  = issue_fire ? sweep_idx : '0;
   assign tail          = tag_pipe[QUERY_LATENCY-1];

   // A response belongs to the tail tag; anything else is a protocol error. Only
   // a matched, root, nonzero-size response is ranked.
   assign rank_en       = tail.valid && resp_valid && resp_is_root && (resp_size != '0);
   assign proto_err     = armed && (resp_valid != tail.valid);

   assign busy          = (state != IDLE);
   assign query_valid   = (state == ISSUE);
   assign out_valid     = (state == HOLD);
   assign query_index   = sweep_idx;

   // Any tag still short of the tail means responses remain after this cycle.
   always_comb begin
      upstream_busy = 1'b0;
      for (int i = 0; i < QUERY_LATENCY - 1; i++) begin
         upstream_busy = upstream_busy | tag_pipe[i].valid;
      end
   end

   // Sweep FSM: start latch, index issue, pipeline drain and result hold.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement or block ordering.
      if (!rst_n) begin
         state     <= IDLE;
         count_q   <= '0;
         mode_q    <= 1'b0;
         armed     <= 1'b0;
         sweep_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  count_q   <= clamped_count;
                  mode_q    <= mode_smallest;
                  armed     <= 1'b1;
                  sweep_idx <= '0;
                  state     <= (clamped_count == '0) ? HOLD : ISSUE;
               end
            end
            ISSUE: begin
               if (query_ready) begin
                  if (last_issue) begin
                     state <= DRAIN;
                  end else begin
                     sweep_idx <= sweep_idx + INDEX_BIT_WIDTH'(1);
                  end
               end
            end
            DRAIN: begin
               if (!upstream_busy) begin
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag pipeline: one {valid, index} entry per accepted query, QUERY_LATENCY deep.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < QUERY_LATENCY; i++) begin
            tag_pipe[i] <= '0;
         end
      end else begin
         tag_pipe[0] <= in_tag;
         for (int i = 1; i < QUERY_LATENCY; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   topn_insert #(
      .TOP_N           (TOP_N),
      .SIZE_BIT_WIDTH  (SIZE_BIT_WIDTH),
      .INDEX_BIT_WIDTH (INDEX_BIT_WIDTH),
      .COUNT_BIT_WIDTH (COUNT_BIT_WIDTH)
   ) u_insert (
      .sizes         (top_sizes),
      .roots         (top_roots),
      .count         (top_count),
      .cand_size     (resp_size),
      .cand_root     (tail.index),
      .mode_smallest (mode_q),
      .next_sizes    (next_sizes),
      .next_roots    (next_roots),
      .next_count    (next_count)
   );

   // Result registers: cleared on start, updated per ranked response, error is sticky.
   always_ff @(posedge clk) begin
      // NOTE: the slot array is a handful of flops, not a RAM, so it is reset;
      // empty slots must read as zero from the first cycle.
      if (!rst_n) begin
         for (int d = 0; d < TOP_N; d++) begin
            top_sizes[d] <= '0;
            top_roots[d] <= '0;
         end
         top_count  <= '0;
         root_count <= '0;
         resp_error <= 1'b0;
      end else if (start_accept) begin
         for (int d = 0; d < TOP_N; d++) begin
            top_sizes[d] <= '0;
            top_roots[d] <= '0;
         end
         top_count  <= '0;
         root_count <= '0;
         resp_error <= 1'b0;
      end else begin
         if (rank_en) begin
            top_sizes  <= next_sizes;
            top_roots  <= next_roots;
            top_count  <= next_count;
            root_count <= root_count + SIZE_BIT_WIDTH'(1);
         end
         if (proto_err) begin
            resp_error <= 1'b1;
         end
      end
   end

   // Product over filled slots only; zero when nothing is ranked.
   always_comb begin
      top_product = '0;
      if (top_count != '0) begin
         top_product = PRODUCT_BIT_WIDTH'(1);
         for (int d = 0; d < TOP_N; d++) begin
            if (d < int'(top_count)) begin
               top_product = top_product * PRODUCT_BIT_WIDTH'(top_sizes[d]);
            end
         end
      end
   end

endmodule

// File: tb/tb_component_topn_sweep.sv
// Self-checking bench for component_topn_sweep: a union-find responder with
// fixed latency drives the query port, and a rank-by-selection reference model
// predicts the top-N list, counts, product, error flag and output timing.
module tb_component_topn_sweep;

   localparam int MAX_NODE_COUNT = 20;
   localparam int TOP_N          = 3;
   localparam int QL             = 3;
   localparam int SW             = $clog2(MAX_NODE_COUNT + 1);
   localparam int IW             = $clog2(MAX_NODE_COUNT);
   localparam int CW             = $clog2(TOP_N + 1);
   localparam int PW             = SW * TOP_N;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [SW-1:0] node_count;
   logic          mode_smallest;
   logic          busy;
   logic          query_valid;
   logic          query_ready;
   logic [IW-1:0] query_index;
   logic          resp_valid;
   logic          resp_is_root;
   logic [SW-1:0] resp_size;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] top_sizes [0:TOP_N-1];
   logic [IW-1:0] top_roots [0:TOP_N-1];
   logic [CW-1:0] top_count;
   logic [SW-1:0] root_count;
   logic [PW-1:0] top_product;
   logic          resp_error;

   always #5 clk = ~clk;

   component_topn_sweep #(
      .MAX_NODE_COUNT (MAX_NODE_COUNT),
      .TOP_N          (TOP_N),
      .QUERY_LATENCY  (QL)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .node_count    (node_count),
      .mode_smallest (mode_smallest),
      .busy          (busy),
      .query_valid   (query_valid),
      .query_ready   (query_ready),
      .query_index   (query_index),
      .resp_valid    (resp_valid),
      .resp_is_root  (resp_is_root),
      .resp_size     (resp_size),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .top_sizes     (top_sizes),
      .top_roots     (top_roots),
      .top_count     (top_count),
      .root_count    (root_count),
      .top_product   (top_product),
      .resp_error    (resp_error)
   );

   int checks;
   int failures;

   // Union-find contents seen by the responder.
   bit node_root [0:MAX_NODE_COUNT-1];
   int node_size [0:MAX_NODE_COUNT-1];

   // Responder and sweep observation state.
   int cyc;
   int pend_due [$];
   int pend_idx [$];
   int hs_count;
   int last_hs_cyc;
   int out_cyc;
   bit hs_order_ok;
   bit hs_timing_ok;
   bit gated;
   bit spurious;
   int withhold;

   // Reference model results.
   int     exp_size [0:TOP_N-1];
   int     exp_root [0:TOP_N-1];
   int     exp_count;
   int     exp_rc;
   longint exp_prod;

   task automatic check(input string tag, input logic [63:0] observed,
                        input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One clock cycle: observe at the falling edge, then drive the next cycle's
   // inputs 1 time unit after the rising edge.
   task automatic step();
      int idx;
      @(negedge clk);
      if (query_valid && query_ready) begin
         if (int'(query_index) != hs_count) hs_order_ok = 1'b0;
         if (cyc != 1 + hs_count) hs_timing_ok = 1'b0;
         pend_due.push_back(cyc + QL);
         pend_idx.push_back(int'(query_index));
         last_hs_cyc = cyc;
         hs_count++;
      end
      if (out_valid && out_cyc < 0) out_cyc = cyc;
      @(posedge clk);
      #1;
      cyc++;
      start        = 1'b0;
      query_ready  = gated ? ((cyc % 3) == 1) : 1'b1;
      resp_valid   = 1'b0;
      resp_is_root = 1'b0;
      resp_size    = '0;
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
         idx = pend_idx.pop_front();
         void'(pend_due.pop_front());
         if (idx != withhold) begin
            resp_valid   = 1'b1;
            resp_is_root = node_root[idx];
            resp_size    = SW'(node_size[idx]);
         end
      end else if (spurious) begin
         resp_valid   = 1'b1;
         resp_is_root = 1'b1;
         resp_size    = SW'(5);
         spurious     = 1'b0;
      end
   endtask

   function automatic bit is_cand(input int k, input int wh);
      return node_root[k] && (node_size[k] != 0) && (k != wh);
   endfunction

   // Rank by repeated selection of the best unused root; strict comparison keeps
   // the lowest index on ties.
   function automatic void compute_model(input int n_eff, input bit mode, input int wh);
      bit used [0:MAX_NODE_COUNT-1];
      int best;
      exp_rc = 0;
      for (int k = 0; k < MAX_NODE_COUNT; k++) used[k] = 1'b0;
      for (int k = 0; k < n_eff; k++) if (is_cand(k, wh)) exp_rc++;
      exp_count = 0;
      exp_prod  = 1;
      for (int s = 0; s < TOP_N; s++) begin
         best = -1;
         for (int k = 0; k < n_eff; k++) begin
            if (is_cand(k, wh) && !used[k]) begin
               if (best < 0 || (mode ? (node_size[k] < node_size[best])
                                     : (node_size[k] > node_size[best]))) best = k;
            end
         end
         if (best >= 0) begin
            used[best]  = 1'b1;
            exp_size[s] = node_size[best];
            exp_root[s] = best;
            exp_count++;
            exp_prod    = exp_prod * node_size[best];
         end else begin
            exp_size[s] = 0;
            exp_root[s] = 0;
         end
      end
      if (exp_count == 0) exp_prod = 0;
   endfunction

   task automatic clear_table();
      for (int k = 0; k < MAX_NODE_COUNT; k++) begin
         node_root[k] = 1'b0;
         node_size[k] = $urandom_range(20, 1);
      end
   endtask

   task automatic random_table();
      for (int k = 0; k < MAX_NODE_COUNT; k++) begin
         node_root[k] = 1'($urandom_range(1, 0));
         node_size[k] = $urandom_range(20, 0);
      end
   endtask

   task automatic set_node(input int k, input int sz);
      node_root[k] = 1'b1;
      node_size[k] = sz;
   endtask

   // Full sweep from start to result handshake with all result checks.
   task automatic run_sweep(input string name, input int n, input bit mode, input bit g,
                            input int wh, input bit exp_err);
      int n_eff;
      int exp_last;
      n_eff    = (n > MAX_NODE_COUNT) ? MAX_NODE_COUNT : n;
      exp_last = g ? 1 + 3 * (n_eff - 1) : n_eff;
      compute_model(n_eff, mode, wh);
      gated    = g;
      withhold = wh;
      pend_due.delete();
      pend_idx.delete();
      hs_count     = 0;
      hs_order_ok  = 1'b1;
      hs_timing_ok = 1'b1;
      last_hs_cyc  = -1;
      out_cyc      = -1;
      node_count    = SW'(n);
      mode_smallest = mode;
      start         = 1'b1;
      cyc           = 0;
      for (int i = 0; i < 300 && out_cyc < 0; i++) step();
      check($sformatf("%s_out_valid_seen", name), out_cyc >= 0, 1);
      check($sformatf("%s_out_cycle", name), out_cyc, (n_eff == 0) ? 1 : exp_last + QL + 1);
      check($sformatf("%s_query_count", name), hs_count, n_eff);
      check($sformatf("%s_query_order", name), hs_order_ok, 1);
      if (!g) check($sformatf("%s_query_timing", name), hs_timing_ok, 1);
      if (n_eff > 0) check($sformatf("%s_last_query_cycle", name), last_hs_cyc, exp_last);
      for (int s = 0; s < TOP_N; s++) begin
         check($sformatf("%s_size%0d", name, s), top_sizes[s], exp_size[s]);
         check($sformatf("%s_root%0d", name, s), top_roots[s], exp_root[s]);
      end
      check($sformatf("%s_top_count", name), top_count, exp_count);
      check($sformatf("%s_root_count", name), root_count, exp_rc);
      check($sformatf("%s_product", name), top_product, exp_prod);
      check($sformatf("%s_resp_error", name), resp_error, exp_err);
      check($sformatf("%s_busy_hold", name), busy, 1);
      // A start pulse while holding must be ignored.
      start = 1'b1;
      step();
      check($sformatf("%s_hold_start_ignored", name), out_valid, 1);
      check($sformatf("%s_hold_root_count", name), root_count, exp_rc);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check($sformatf("%s_out_valid_drop", name), out_valid, 0);
      check($sformatf("%s_idle_busy", name), busy, 0);
      check($sformatf("%s_result_kept", name), top_product, exp_prod);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      start         = 1'b0;
      node_count    = '0;
      mode_smallest = 1'b0;
      query_ready   = 1'b0;
      resp_valid    = 1'b0;
      resp_is_root  = 1'b0;
      resp_size     = '0;
      out_ready     = 1'b0;
      gated         = 1'b0;
      spurious      = 1'b0;
      withhold      = -1;
      cyc           = 0;
      hs_count      = 0;
      out_cyc       = -1;

      // Reset state.
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_query_valid", query_valid, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_resp_error", resp_error, 0);
      check("rst_top_count", top_count, 0);
      check("rst_root_count", root_count, 0);
      check("rst_product", top_product, 0);
      for (int s = 0; s < TOP_N; s++) begin
         check($sformatf("rst_size%0d", s), top_sizes[s], 0);
         check($sformatf("rst_root%0d", s), top_roots[s], 0);
      end
      rst_n = 1'b1;
      step();

      // Directed largest-first example.
      clear_table();
      set_node(0, 3);
      set_node(2, 1);
      set_node(4, 2);
      run_sweep("largest", 6, 1'b0, 1'b0, -1, 1'b0);
      check("largest_fixed_size0", top_sizes[0], 3);
      check("largest_fixed_size2", top_sizes[2], 1);
      check("largest_fixed_root1", top_roots[1], 4);
      check("largest_fixed_product", top_product, 6);

      // Same nodes, smallest-first.
      run_sweep("smallest", 6, 1'b1, 1'b0, -1, 1'b0);
      check("smallest_fixed_root0", top_roots[0], 2);
      check("smallest_fixed_size2", top_sizes[2], 3);

      // Only two roots: partial fill.
      clear_table();
      set_node(1, 5);
      set_node(3, 2);
      run_sweep("two_roots", 6, 1'b1, 1'b0, -1, 1'b0);
      check("two_roots_fixed_count", top_count, 2);
      check("two_roots_fixed_slot2", top_sizes[2], 0);
      check("two_roots_fixed_product", top_product, 10);

      // Ties keep the lower index first.
      clear_table();
      set_node(1, 4);
      set_node(5, 4);
      set_node(3, 5);
      run_sweep("tie", 6, 1'b0, 1'b0, -1, 1'b0);
      check("tie_fixed_root0", top_roots[0], 3);
      check("tie_fixed_root1", top_roots[1], 1);
      check("tie_fixed_root2", top_roots[2], 5);

      // Random nodes, free-running then with query_ready backpressure.
      random_table();
      run_sweep("ungated", 12, 1'b0, 1'b0, -1, 1'b0);
      run_sweep("gated", 12, 1'b0, 1'b1, -1, 1'b0);
      run_sweep("gated_small", 9, 1'b1, 1'b1, -1, 1'b0);

      // Protocol errors: spurious response in IDLE, then a withheld response.
      clear_table();
      set_node(0, 3);
      set_node(2, 1);
      set_node(4, 2);
      spurious = 1'b1;
      step();
      step();
      check("spurious_idle_error", resp_error, 1);
      run_sweep("withheld", 6, 1'b0, 1'b0, 2, 1'b1);
      run_sweep("error_cleared", 6, 1'b0, 1'b0, -1, 1'b0);

      // Zero-length sweep and count clamping.
      run_sweep("zero_count", 0, 1'b0, 1'b0, -1, 1'b0);
      random_table();
      run_sweep("clamp", 25, 1'b1, 1'b0, -1, 1'b0);

      // Randomized sweeps.
      for (int r = 0; r < 4; r++) begin
         random_table();
         run_sweep($sformatf("rand%0d", r), $urandom_range(MAX_NODE_COUNT, 1),
                   1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), -1, 1'b0);
      end

      // Reset in the middle of ISSUE abandons the sweep.
      for (int k = 0; k < MAX_NODE_COUNT; k++) begin
         node_root[k] = 1'b1;
         node_size[k] = 7;
      end
      gated    = 1'b0;
      withhold = -1;
      pend_due.delete();
      pend_idx.delete();
      hs_count      = 0;
      out_cyc       = -1;
      node_count    = SW'(10);
      mode_smallest = 1'b0;
      start         = 1'b1;
      cyc           = 0;
      repeat (4) step();
      check("midrst_issuing", query_valid, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midrst_busy", busy, 0);
      check("midrst_query_valid", query_valid, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_top_count", top_count, 0);
      check("midrst_root_count", root_count, 0);
      check("midrst_size0", top_sizes[0], 0);
      repeat (6) step();
      check("late_resp_root_count", root_count, 0);
      check("late_resp_top_count", top_count, 0);
      check("late_resp_error", resp_error, 0);
      check("late_resp_busy", busy, 0);
      check("late_resp_product", top_product, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
